uart_fifo_cpu: RTL and testbench

UART_FIFO_CPU -- requirements
Module: uart_fifo_cpu

---
 rtl/uart_fifo_cpu.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_cpu.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_cpu.sv
// UART with TX/RX byte FIFOs behind a six-register CPU window.
// Holds the FIFO, the 16x-oversampling UART core and the bus/sequencing top.

module uart_fifo_sync #(
  parameter int Depth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic                    pop,
  input  logic [7:0]              wdata,
  output logic [7:0]              rdata,
  output logic [$clog2(Depth):0]  count,
  output logic                    full
);
  localparam int Aw = $clog2(Depth);

  logic [7:0]  mem [Depth];
  logic [Aw:0] wptr, rptr;
  logic        empty, do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[Aw] != rptr[Aw]) && (wptr[Aw-1:0] == rptr[Aw-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  // a full FIFO still takes a byte when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? 8'h00 : mem[rptr[Aw-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (Aw+1)'(1);
      if (do_pop)  rptr <= rptr + (Aw+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr[Aw-1:0]] <= wdata;
  end
endmodule

module uart_core #(
  parameter int ClkHz = 0,
  parameter int Baud  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_line,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid
);
  localparam int BaudX16 = (Baud > 0) ? Baud * 16 : 1;
  localparam int OsDiv   = ((ClkHz / BaudX16) > 1) ? (ClkHz / BaudX16) : 1;

  logic [31:0] os_cnt;
  logic        os_tick;
  logic        tx_busy, rx_busy, rx_deb;
  logic [8:0]  tx_shift;
  logic [3:0]  tx_bits, tx_ticks, rx_idx, rx_ticks;
  logic [2:0]  rx_pipe;
  logic [7:0]  rx_shift;

  assign os_tick  = (os_cnt == 32'd0);
  assign tx_ready = !tx_busy;
  assign rx_data  = rx_shift;

  always_ff @(posedge clk) begin
    if (rst || os_tick) os_cnt <= 32'(OsDiv - 1);
    else                os_cnt <= os_cnt - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      tx_line  <= 1'b1;
      tx_shift <= '0;
      tx_bits  <= '0;
      tx_ticks <= '0;
    end else if (!tx_busy) begin
      if (tx_valid) begin
        tx_busy  <= 1'b1;
        tx_line  <= 1'b0;
        tx_shift <= {1'b1, tx_data};
        tx_bits  <= 4'd9;
        tx_ticks <= 4'd15;
      end
    end else if (os_tick) begin
      if (tx_ticks != 4'd0) begin
        tx_ticks <= tx_ticks - 4'd1;
      end else if (tx_bits == 4'd0) begin
        tx_busy <= 1'b0;
        tx_line <= 1'b1;
      end else begin
        tx_line  <= tx_shift[0];
        tx_shift <= {1'b0, tx_shift[8:1]};
        tx_bits  <= tx_bits - 4'd1;
        tx_ticks <= 4'd15;
      end
    end
  end

  // two-flop synchroniser, then the line only changes once two samples agree
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_pipe <= 3'b111;
      rx_deb  <= 1'b1;
    end else begin
      rx_pipe <= {rx_pipe[1:0], rx_line};
      if (rx_pipe[2] == rx_pipe[1]) rx_deb <= rx_pipe[2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_busy  <= 1'b0;
      rx_idx   <= '0;
      rx_ticks <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_busy) begin
        if (!rx_deb) begin
          rx_busy  <= 1'b1;
          rx_idx   <= '0;
          rx_ticks <= 4'd7;
        end
      end else if (os_tick) begin
        if (rx_ticks != 4'd0) begin
          rx_ticks <= rx_ticks - 4'd1;
        end else begin
          rx_ticks <= 4'd15;
          rx_idx   <= rx_idx + 4'd1;
          if (rx_idx == 4'd0) begin
            if (rx_deb) rx_busy <= 1'b0;
          end else if (rx_idx == 4'd9) begin
            rx_busy  <= 1'b0;
            rx_valid <= rx_deb;
          end else begin
            rx_shift <= {rx_deb, rx_shift[7:1]};
          end
        end
      end
    end
  end
endmodule

module uart_fifo_cpu #(
  parameter int BaseAddress     = 0,
  parameter int Address_Wording = 1,
  parameter int FPGAClkSpeed    = 0,
  parameter int UARTBaudRate    = 0,
  parameter int TxDepth         = 16,
  parameter int RxDepth         = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] address_i,
  input  logic [7:0]  data_i,
  input  logic        rd_wr_i,
  output logic [7:0]  data_o,
  output logic        take_controlr_o,
  output logic        take_controlw_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i,
  output logic        irq_o
);
  // state     | meaning
  // IDLE      | waiting for a queued byte and a ready core
  // ISSUE     | data-valid to the core for one cycle
  // WAIT_BUSY | waiting for the core to accept (ready low)
  // WAIT_DONE | frame on the line, waiting for ready again
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} tx_state_t;

  function automatic logic [15:0] reg_addr(input int k);
    return 16'(BaseAddress + k * Address_Wording);
  endfunction

  tx_state_t state, state_nx;

  logic hit_txd, hit_rxd, hit_stat, hit_ctrl, hit_cnt, hit_thr;
  logic rd_hit, wr_hit, rxd_rd, rxd_rd_q, rx_pop, ctrl_wr, rx_flush, tx_flush;
  logic tx_push, tx_pop, tx_full, tx_empty, tx_idle, tx_drop;
  logic rx_full, rx_empty, rx_drop;
  logic core_valid, core_ready, core_rx_valid;
  logic rx_irq_en, tx_irq_en, rx_overrun, tx_overflow, irq_nx;
  logic [7:0] tx_head, tx_hold, rx_head, core_rx_data, rx_thresh, thr_eff;
  logic [7:0] status, rd_mux, rx_count_sat;
  logic [$clog2(TxDepth):0] tx_count;
  logic [$clog2(RxDepth):0] rx_count;

  assign hit_txd  = (address_i == reg_addr(0));
  assign hit_rxd  = (address_i == reg_addr(1));
  assign hit_stat = (address_i == reg_addr(2));
  assign hit_ctrl = (address_i == reg_addr(3));
  assign hit_cnt  = (address_i == reg_addr(4));
  assign hit_thr  = (address_i == reg_addr(5));

  assign rd_hit   = !rd_wr_i && (hit_rxd || hit_stat || hit_ctrl || hit_cnt || hit_thr);
  assign wr_hit   = rd_wr_i && (hit_txd || hit_ctrl || hit_thr);
  assign rxd_rd   = !rd_wr_i && hit_rxd;
  assign rx_pop   = rxd_rd && !rxd_rd_q;
  assign ctrl_wr  = rd_wr_i && hit_ctrl;
  assign rx_flush = ctrl_wr && data_i[2];
  assign tx_flush = ctrl_wr && data_i[3];
  assign tx_push  = rd_wr_i && hit_txd;

  assign tx_empty = (tx_count == '0);
  assign rx_empty = (rx_count == '0);
  assign tx_idle  = tx_empty && (state == IDLE) && core_ready;
  assign tx_drop  = tx_push && tx_full && !tx_pop && !tx_flush;
  assign rx_drop  = core_rx_valid && rx_full && !rx_pop && !rx_flush;

  assign thr_eff      = (rx_thresh == 8'd0) ? 8'd1 : rx_thresh;
  assign rx_count_sat = (32'(rx_count) > 32'd255) ? 8'hFF : 8'(rx_count);
  assign irq_nx = (rx_irq_en && (32'(rx_count) >= 32'(thr_eff))) || (tx_irq_en && tx_idle);
  assign status = {irq_o, tx_overflow, rx_overrun, tx_idle, tx_full, tx_empty, rx_full, rx_empty};

  uart_fifo_sync #(.Depth(TxDepth)) u_tx_fifo (
    .clk(clk_i), .rst(reset_i), .flush(tx_flush), .push(tx_push), .pop(tx_pop),
    .wdata(data_i), .rdata(tx_head), .count(tx_count), .full(tx_full)
  );

  uart_fifo_sync #(.Depth(RxDepth)) u_rx_fifo (
    .clk(clk_i), .rst(reset_i), .flush(rx_flush), .push(core_rx_valid), .pop(rx_pop),
    .wdata(core_rx_data), .rdata(rx_head), .count(rx_count), .full(rx_full)
  );

  uart_core #(.ClkHz(FPGAClkSpeed), .Baud(UARTBaudRate)) u_core (
    .clk(clk_i), .rst(reset_i),
    .tx_data(tx_hold), .tx_valid(core_valid), .tx_ready(core_ready), .tx_line(uart_tx_o),
    .rx_line(uart_rx_i), .rx_data(core_rx_data), .rx_valid(core_rx_valid)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      tx_hold <= 8'h00;
    end else begin
      state <= state_nx;
      if (tx_pop) tx_hold <= tx_head;
    end
  end

  always_comb begin
    state_nx   = state;
    tx_pop     = 1'b0;
    core_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_empty && core_ready && !tx_flush) begin
          tx_pop   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        core_valid = 1'b1;
        state_nx   = WAIT_BUSY;
      end
      WAIT_BUSY: if (!core_ready) state_nx = WAIT_DONE;
      WAIT_DONE: if (core_ready)  state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_irq_en   <= 1'b0;
      tx_irq_en   <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
      rx_thresh   <= 8'd1;
    end else begin
      if (ctrl_wr) begin
        rx_irq_en <= data_i[0];
        tx_irq_en <= data_i[1];
        if (data_i[5]) rx_overrun  <= 1'b0;
        if (data_i[6]) tx_overflow <= 1'b0;
      end
      if (rx_drop) rx_overrun  <= 1'b1;
      if (tx_drop) tx_overflow <= 1'b1;
      if (rd_wr_i && hit_thr) rx_thresh <= data_i;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    if (hit_stat)      rd_mux = status;
    else if (hit_ctrl) rd_mux = {6'b0, tx_irq_en, rx_irq_en};
    else if (hit_cnt)  rd_mux = rx_count_sat;
    else if (hit_thr)  rd_mux = rx_thresh;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_o          <= 8'h00;
      take_controlr_o <= 1'b0;
      take_controlw_o <= 1'b0;
      rxd_rd_q        <= 1'b0;
      irq_o           <= 1'b0;
    end else begin
      take_controlr_o <= rd_hit;
      take_controlw_o <= wr_hit;
      rxd_rd_q        <= rxd_rd;
      irq_o           <= irq_nx;
      // a held RXDATA read keeps showing the byte popped on its first cycle
      if (!rd_hit)      data_o <= 8'h00;
      else if (hit_rxd) begin
        if (rx_pop) data_o <= rx_head;
      end else          data_o <= rd_mux;
    end
  end
endmodule

// File: tb/tb_uart_fifo_cpu.sv
// Bench for uart_fifo_cpu: register table, loopback scenarios and randomized traffic
// checked against queue-based expectations and an independent serial-line decoder.

module tb_uart_fifo_cpu;
  localparam logic [15:0] A_TXD  = 16'h0020;
  localparam logic [15:0] A_RXD  = 16'h0022;
  localparam logic [15:0] A_STAT = 16'h0024;
  localparam logic [15:0] A_CTRL = 16'h0026;
  localparam logic [15:0] A_CNT  = 16'h0028;
  localparam logic [15:0] A_THR  = 16'h002A;
  localparam logic [15:0] A_IDLE = 16'h0100;
  localparam int TXD = 4;
  localparam int RXD = 4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] address = A_IDLE;
  logic [7:0]  data_in = 8'h00;
  logic        rd_wr = 1'b0;
  logic [7:0]  data_o;
  logic        take_r, take_w, tx_line, irq;
  wire         rx_line;

  assign rx_line = tx_line;

  uart_fifo_cpu #(
    .BaseAddress(32), .Address_Wording(2), .FPGAClkSpeed(1_600_000),
    .UARTBaudRate(100_000), .TxDepth(TXD), .RxDepth(RXD)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .address_i(address), .data_i(data_in),
    .rd_wr_i(rd_wr), .data_o(data_o), .take_controlr_o(take_r),
    .take_controlw_o(take_w), .uart_tx_o(tx_line), .uart_rx_i(rx_line), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rw;
    logic [7:0]  exp_data;
    logic        exp_tr;
    logic        exp_tw;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int frame_err = 0;
  bit mon_en = 1'b1;
  logic [7:0] mon_q[$];
  logic [7:0] exp_tx[$];

  // independent line decoder: mid-bit sampling at 16 clocks per bit
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx_line);
      repeat (8) @(posedge clk);
      @(negedge clk);
      if (tx_line == 1'b0) begin
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = tx_line;
        end
        repeat (16) @(negedge clk);
        if (mon_en) begin
          if (tx_line !== 1'b1) frame_err++;
          mon_q.push_back(b);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic access(input logic [15:0] a, input logic [7:0] d, input logic rw,
                        output logic [7:0] rd, output logic tr, output logic tw);
    @(negedge clk);
    address = a; data_in = d; rd_wr = rw;
    @(negedge clk);
    rd = data_o; tr = take_r; tw = take_w;
    address = A_IDLE; rd_wr = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] r; logic tr, tw;
    access(a, d, 1'b1, r, tr, tw);
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] v);
    logic tr, tw;
    access(a, 8'h00, 1'b0, v, tr, tw);
  endtask

  task automatic expect_reg(input string name, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    check(name, v, exp);
  endtask

  task automatic send(input logic [7:0] b);
    wr(A_TXD, b);
    exp_tx.push_back(b);
  endtask

  task automatic new_section();
    mon_q.delete();
    exp_tx.delete();
    frame_err = 0;
  endtask

  task automatic wait_frames(input int n);
    int c = 0;
    while (mon_q.size() < n && c < n * 200 + 400) begin
      @(negedge clk);
      c++;
    end
    check("frame_wait", mon_q.size() >= n, 1);
    repeat (24) @(negedge clk);
  endtask

  task automatic check_frames(input string tag);
    check({tag, "_frames"}, mon_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < mon_q.size(); i++)
      check({tag, "_byte"}, mon_q[i], exp_tx[i]);
    check({tag, "_stop"}, frame_err, 0);
  endtask

  task automatic read_back(input string tag, input int n);
    logic [7:0] v;
    for (int i = 0; i < n && i < exp_tx.size(); i++) begin
      rd(A_RXD, v);
      check({tag, "_rx"}, v, exp_tx[i]);
    end
  endtask

  initial begin
    vec_t vecs[$];
    logic [7:0] v, b0;
    logic tr, tw;
    int n, thr, en, thr_eff;

    vecs.push_back('{"stat_rst",   A_STAT,   8'h00, 1'b0, 8'h15, 1'b1, 1'b0});
    vecs.push_back('{"ctrl_rst",   A_CTRL,   8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{"cnt_rst",    A_CNT,    8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{"thr_rst",    A_THR,    8'h00, 1'b0, 8'h01, 1'b1, 1'b0});
    vecs.push_back('{"rxd_empty",  A_RXD,    8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{"miss_rd",    16'h0025, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{"miss_k6",    16'h002C, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{"thr_wr",     A_THR,    8'h07, 1'b1, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{"thr_rd",     A_THR,    8'h00, 1'b0, 8'h07, 1'b1, 1'b0});
    vecs.push_back('{"stat_wr_ro", A_STAT,   8'hFF, 1'b1, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{"rxd_wr_ro",  A_RXD,    8'hAA, 1'b1, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{"cnt_wr_ro",  A_CNT,    8'h05, 1'b1, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{"cnt_after",  A_CNT,    8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{"ctrl_wr",    A_CTRL,   8'h6F, 1'b1, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{"ctrl_rd",    A_CTRL,   8'h00, 1'b0, 8'h03, 1'b1, 1'b0});
    vecs.push_back('{"stat_irq",   A_STAT,   8'h00, 1'b0, 8'h95, 1'b1, 1'b0});
    vecs.push_back('{"ctrl_wr0",   A_CTRL,   8'h00, 1'b1, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{"stat_noirq", A_STAT,   8'h00, 1'b0, 8'h15, 1'b1, 1'b0});
    vecs.push_back('{"thr_wr0",    A_THR,    8'h00, 1'b1, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{"thr_rd0",    A_THR,    8'h00, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{"miss_wr",    16'h0021, 8'h55, 1'b1, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{"stat_end",   A_STAT,   8'h00, 1'b0, 8'h15, 1'b1, 1'b0});

    // reset behaviour
    repeat (3) @(negedge clk);
    check("rst_tx_line", tx_line, 1'b1);
    check("rst_data_o", data_o, 8'h00);
    check("rst_take_r", take_r, 1'b0);
    check("rst_take_w", take_w, 1'b0);
    check("rst_irq", irq, 1'b0);
    reset_i = 1'b0;

    // register decode table
    foreach (vecs[i]) begin
      access(vecs[i].addr, vecs[i].wdata, vecs[i].rw, v, tr, tw);
      check({vecs[i].name, "_data"}, v, vecs[i].exp_data);
      check({vecs[i].name, "_tr"}, tr, vecs[i].exp_tr);
      check({vecs[i].name, "_tw"}, tw, vecs[i].exp_tw);
    end
    wr(A_THR, 8'h01);
    repeat (200) @(negedge clk);

    // three frames in order, tx_idle after the last stop bit
    new_section();
    send(8'h55); send(8'hA3); send(8'h0F);
    wait_frames(3);
    check_frames("three");
    expect_reg("three_stat", A_STAT, 8'h15 & ~8'h01);
    read_back("three", 3);
    expect_reg("three_idle", A_STAT, 8'h15);

    // RX overrun through loopback
    new_section();
    for (int i = 0; i < RXD + 1; i++) send(8'($urandom_range(0, 255)));
    wait_frames(RXD + 1);
    check_frames("ovr");
    expect_reg("ovr_cnt", A_CNT, 8'(RXD));
    expect_reg("ovr_stat", A_STAT, 8'h36);
    read_back("ovr", RXD);
    wr(A_CTRL, 8'h20);
    expect_reg("ovr_clr", A_STAT, 8'h15);

    // held RXDATA read pops once
    new_section();
    send(8'h3C); send(8'hC3);
    wait_frames(2);
    expect_reg("hold_cnt2", A_CNT, 8'd2);
    @(negedge clk);
    address = A_RXD; rd_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_take_r", take_r, 1'b1);
      if (i == 0) check("hold_data", data_o, 8'h3C);
    end
    address = A_IDLE;
    expect_reg("hold_cnt1", A_CNT, 8'd1);
    expect_reg("hold_second", A_RXD, 8'hC3);

    // RX threshold interrupt
    new_section();
    wr(A_THR, 8'd3);
    wr(A_CTRL, 8'h01);
    send(8'h11); send(8'h22); send(8'h33);
    wait_frames(2);
    check("thr_irq_low", irq, 1'b0);
    wait_frames(3);
    check("thr_irq_high", irq, 1'b1);
    expect_reg("thr_pop", A_RXD, 8'h11);
    repeat (2) @(negedge clk);
    check("thr_irq_clear", irq, 1'b0);
    wr(A_CTRL, 8'h24);
    wr(A_THR, 8'd1);

    // TX overflow while the line is busy
    new_section();
    for (int i = 0; i < TXD + 2; i++) begin
      b0 = 8'($urandom_range(0, 255));
      wr(A_TXD, b0);
      if (i <= TXD) exp_tx.push_back(b0);
    end
    expect_reg("txovf_stat", A_STAT, 8'h49);
    wr(A_CTRL, 8'h40);
    expect_reg("txovf_clr", A_STAT, 8'h09);
    wait_frames(TXD + 1);
    check_frames("txovf");
    wr(A_CTRL, 8'h64);
    expect_reg("txovf_end", A_STAT, 8'h15);

    // tx_flush keeps the byte already issued
    new_section();
    send(8'hE1);
    wr(A_TXD, 8'hE2);
    wr(A_TXD, 8'hE3);
    wr(A_CTRL, 8'h08);
    expect_reg("flush_stat", A_STAT, 8'h05);
    wait_frames(1);
    repeat (200) @(negedge clk);
    check_frames("flush");
    wr(A_CTRL, 8'h04);

    // randomized loopback traffic against the queue model
    for (int r = 0; r < 6; r++) begin
      new_section();
      n = $urandom_range(1, RXD);
      thr = $urandom_range(0, 5);
      en = $urandom_range(0, 1);
      thr_eff = (thr == 0) ? 1 : thr;
      wr(A_THR, 8'(thr));
      wr(A_CTRL, 8'(en));
      for (int i = 0; i < n; i++) begin
        send(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      wait_frames(n);
      check_frames("rnd");
      expect_reg("rnd_cnt", A_CNT, 8'(n));
      for (int i = 0; i < n; i++) begin
        check("rnd_irq", irq, (en == 1) && (n - i >= thr_eff));
        expect_reg("rnd_rx", A_RXD, exp_tx[i]);
      end
      expect_reg("rnd_empty_rd", A_RXD, 8'h00);
      expect_reg("rnd_stat", A_STAT, 8'h15);
    end

    // reset in the middle of a frame
    new_section();
    wr(A_CTRL, 8'h02);
    wr(A_TXD, 8'h00);
    repeat (40) @(negedge clk);
    mon_en = 1'b0;
    reset_i = 1'b1;
    @(negedge clk);
    check("midrst_tx_line", tx_line, 1'b1);
    check("midrst_irq", irq, 1'b0);
    check("midrst_data_o", data_o, 8'h00);
    reset_i = 1'b0;
    expect_reg("midrst_stat", A_STAT, 8'h15);
    expect_reg("midrst_ctrl", A_CTRL, 8'h00);
    expect_reg("midrst_thr", A_THR, 8'h01);
    repeat (200) @(negedge clk);
    check("midrst_line_idle", tx_line, 1'b1);
    expect_reg("midrst_cnt", A_CNT, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
